// File: rtl/draw_block.sv
// Obstacle renderer: on each frame_tick, erases the previous block and draws the new one,
// one pixel per cycle with off-screen clipping. Optional macro: DRAW_SKIP_UNCHANGED_EN.
module draw_block #(
    parameter int unsigned BLOCK_W   = 8,
    parameter int unsigned BLOCK_H   = 8,
    parameter logic [2:0]  FG_COLOUR = 3'b100,
    parameter logic [2:0]  BG_COLOUR = 3'b000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic [7:0] block_x,
    input  logic [6:0] block_y,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] LAST_PX  = 4'(BLOCK_W - 1);
    localparam logic [3:0] LAST_PY  = 4'(BLOCK_H - 1);
    localparam logic [8:0] SCREEN_W = 9'd160;
    localparam logic [7:0] SCREEN_H = 8'd120;

    typedef enum logic [1:0] {StIdle, StErase, StDraw, StDone} state_t;

    state_t     state;
    logic [3:0] px, py;
    logic [7:0] old_x, new_x;
    logic [6:0] old_y, new_y;
    logic       old_valid;

    logic       last_pix;
    logic [3:0] px_next, py_next;
    logic [7:0] tgt_bx;
    logic [6:0] tgt_by;
    logic [3:0] tgt_px, tgt_py;
    logic [2:0] tgt_colour;
    logic [8:0] sum_x;
    logic [7:0] sum_y;
    logic       on_screen;
    logic       skip;

`ifdef DRAW_SKIP_UNCHANGED_EN
    assign skip = old_valid && (block_x == old_x) && (block_y == old_y);
`else
    assign skip = 1'b0;
`endif

    always_comb begin
        last_pix = (px == LAST_PX) && (py == LAST_PY);
        px_next  = (px == LAST_PX) ? 4'd0 : px + 4'd1;
        py_next  = (px == LAST_PX) ? py + 4'd1 : py;
    end

    // Select the pixel the outputs will present in the next cycle.
    always_comb begin
        tgt_bx     = new_x;
        tgt_by     = new_y;
        tgt_px     = px_next;
        tgt_py     = py_next;
        tgt_colour = FG_COLOUR;
        unique case (state)
            StIdle: begin
                tgt_px = 4'd0;
                tgt_py = 4'd0;
                if (old_valid) begin
                    tgt_bx     = old_x;
                    tgt_by     = old_y;
                    tgt_colour = BG_COLOUR;
                end else begin
                    tgt_bx = block_x;
                    tgt_by = block_y;
                end
            end
            StErase: begin
                if (last_pix) begin
                    tgt_px = 4'd0;
                    tgt_py = 4'd0;
                end else begin
                    tgt_bx     = old_x;
                    tgt_by     = old_y;
                    tgt_colour = BG_COLOUR;
                end
            end
            StDraw: begin
                tgt_colour = FG_COLOUR;
            end
            StDone: begin
                tgt_colour = FG_COLOUR;
            end
            default: begin
                tgt_colour = FG_COLOUR;
            end
        endcase
        // Widened sums so that off-screen pixels are clipped instead of wrapping.
        sum_x     = {1'b0, tgt_bx} + 9'(tgt_px);
        sum_y     = {1'b0, tgt_by} + 8'(tgt_py);
        on_screen = (sum_x < SCREEN_W) && (sum_y < SCREEN_H);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= StIdle;
            px         <= 4'd0;
            py         <= 4'd0;
            old_x      <= 8'd0;
            old_y      <= 7'd0;
            new_x      <= 8'd0;
            new_y      <= 7'd0;
            old_valid  <= 1'b0;
            vga_x      <= 8'd0;
            vga_y      <= 7'd0;
            vga_colour <= BG_COLOUR;
            vga_plot   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    vga_plot <= 1'b0;
                    if (frame_tick) begin
                        new_x <= block_x;
                        new_y <= block_y;
                        px    <= 4'd0;
                        py    <= 4'd0;
                        busy  <= 1'b1;
                        if (skip) begin
                            state <= StDone;
                            done  <= 1'b1;
                        end else begin
                            state      <= old_valid ? StErase : StDraw;
                            vga_x      <= sum_x[7:0];
                            vga_y      <= sum_y[6:0];
                            vga_colour <= tgt_colour;
                            vga_plot   <= on_screen;
                        end
                    end
                end
                StErase: begin
                    px         <= tgt_px;
                    py         <= tgt_py;
                    vga_x      <= sum_x[7:0];
                    vga_y      <= sum_y[6:0];
                    vga_colour <= tgt_colour;
                    vga_plot   <= on_screen;
                    if (last_pix) begin
                        state <= StDraw;
                    end
                end
                StDraw: begin
                    if (last_pix) begin
                        state    <= StDone;
                        done     <= 1'b1;
                        vga_plot <= 1'b0;
                        px       <= 4'd0;
                        py       <= 4'd0;
                    end else begin
                        px         <= tgt_px;
                        py         <= tgt_py;
                        vga_x      <= sum_x[7:0];
                        vga_y      <= sum_y[6:0];
                        vga_colour <= tgt_colour;
                        vga_plot   <= on_screen;
                    end
                end
                StDone: begin
                    old_x     <= new_x;
                    old_y     <= new_y;
                    old_valid <= 1'b1;
                    vga_plot  <= 1'b0;
                    busy      <= 1'b0;
                    state     <= StIdle;
                end
                default: begin
                    state    <= StIdle;
                    vga_plot <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_draw_block.sv
// Scoreboard bench for draw_block: stimulus pushes expected plots/done pulses, a monitor
// pops and compares them on the falling edge.
module tb_draw_block;

    localparam int         W  = 8;
    localparam int         H  = 8;
    localparam logic [2:0] FG = 3'b100;
    localparam logic [2:0] BG = 3'b000;

    typedef struct {
        int         cyc;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    logic       clock;
    logic       reset_n;
    logic       frame_tick;
    logic [7:0] block_x;
    logic [6:0] block_y;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;
    logic       done;

    pix_t exp_q[$];
    int   done_q[$];
    int   cyc;
    int   nvec;
    int   nfail;
    bit   mon_en;

    bit   m_valid;
    int   m_ox, m_oy;

    draw_block #(
        .BLOCK_W  (W),
        .BLOCK_H  (H),
        .FG_COLOUR(FG),
        .BG_COLOUR(BG)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .frame_tick(frame_tick),
        .block_x   (block_x),
        .block_y   (block_y),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .vga_colour(vga_colour),
        .vga_plot  (vga_plot),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: every presented plot / done pulse must match the head of its queue.
    always @(negedge clock) begin
        if (mon_en) begin
            if (vga_plot === 1'b1) begin
                nvec++;
                if (exp_q.size() == 0) begin
                    nfail++;
                    $display("FAIL plot_unexpected: cyc=%0d got (%0d,%0d,c%0d), required no plot",
                             cyc, vga_x, vga_y, vga_colour);
                end else begin
                    pix_t e;
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.x !== vga_x || e.y !== vga_y || e.c !== vga_colour) begin
                        nfail++;
                        $display("FAIL plot: got cyc=%0d (%0d,%0d,c%0d), required cyc=%0d (%0d,%0d,c%0d)",
                                 cyc, vga_x, vga_y, vga_colour, e.cyc, e.x, e.y, e.c);
                    end
                end
            end
            if (done !== 1'b0) begin
                nvec++;
                if (done_q.size() == 0) begin
                    nfail++;
                    $display("FAIL done_unexpected: cyc=%0d done=%b, required 0", cyc, done);
                end else begin
                    int d;
                    d = done_q.pop_front();
                    if (d != cyc) begin
                        nfail++;
                        $display("FAIL done_cycle: got cyc=%0d, required cyc=%0d", cyc, d);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        nvec++;
        if (got !== req) begin
            nfail++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    // Expected pixels of one pass; pixels after a reset cycle are not expected.
    task automatic push_pass(input int t0, input int kstart, input int bx, input int by,
                             input logic [2:0] col, input int rst_at);
        for (int py = 0; py < H; py++) begin
            for (int px = 0; px < W; px++) begin
                int   c, x, y;
                pix_t e;
                c = kstart + py * W + px;
                x = bx + px;
                y = by + py;
                if ((rst_at == 0 || c <= rst_at) && x < 160 && y < 120) begin
                    e.cyc = t0 + c;
                    e.x   = 8'(x);
                    e.y   = 7'(y);
                    e.c   = col;
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic run_frame(input int bx, input int by, input bit extras, input int rst_at);
        int t0, k, off, last_k;
        bit skipm;
        @(negedge clock);
        t0    = cyc;
        skipm = 1'b0;
`ifdef DRAW_SKIP_UNCHANGED_EN
        skipm = m_valid && (bx == m_ox) && (by == m_oy);
`endif
        k = 1;
        if (!skipm) begin
            if (m_valid) begin
                push_pass(t0, k, m_ox, m_oy, BG, rst_at);
                k += W * H;
            end
            push_pass(t0, k, bx, by, FG, rst_at);
            k += W * H;
        end
        off = k;
        if (rst_at == 0 || off <= rst_at) done_q.push_back(t0 + off);
        block_x    = 8'(bx);
        block_y    = 7'(by);
        frame_tick = 1'b1;
        last_k     = (rst_at != 0) ? rst_at + 3 : off + 2;
        for (int j = 1; j <= last_k; j++) begin
            @(negedge clock);
            frame_tick = 1'b0;
            if (extras && (j == 10 || j == off)) begin
                frame_tick = 1'b1;
                block_x    = 8'd99;
                block_y    = 7'd99;
            end
            if (rst_at != 0 && j == rst_at) reset_n = 1'b0;
            if (rst_at != 0 && j == rst_at + 2) reset_n = 1'b1;
            check("busy", 32'(busy), 32'((j <= off) && (rst_at == 0 || j <= rst_at)));
        end
        frame_tick = 1'b0;
        if (rst_at != 0) begin
            m_valid = 1'b0;
        end else begin
            m_valid = 1'b1;
            m_ox    = bx;
            m_oy    = by;
        end
    endtask

    initial begin
        nvec       = 0;
        nfail      = 0;
        mon_en     = 1'b0;
        m_valid    = 1'b0;
        m_ox       = 0;
        m_oy       = 0;
        reset_n    = 1'b0;
        frame_tick = 1'b0;
        block_x    = 8'd0;
        block_y    = 7'd0;
        repeat (3) @(negedge clock);
        check("rst_plot", 32'(vga_plot), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_x", 32'(vga_x), 32'd0);
        check("rst_y", 32'(vga_y), 32'd0);
        check("rst_colour", 32'(vga_colour), 32'(BG));
        reset_n = 1'b1;
        mon_en  = 1'b1;
        @(negedge clock);

        run_frame(20, 30, 1'b0, 0);    // first frame, no erase, done at 65
        run_frame(19, 30, 1'b0, 0);    // erase + draw, done at 129
        run_frame(156, 115, 1'b0, 0);  // clipped draw
        run_frame(40, 50, 1'b1, 0);    // extra ticks at cycle 10 and in DONE
        run_frame(10, 10, 1'b0, 104);  // reset at DRAW cycle 40
        run_frame(50, 60, 1'b0, 0);    // post-reset frame skips erase
        run_frame(50, 60, 1'b0, 0);    // unchanged position

        repeat (4) @(negedge clock);
        check("plots_left", 32'(exp_q.size()), 32'd0);
        check("dones_left", 32'(done_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
